// File: rtl/svc_rv_sram_arb.sv
// svc_rv_sram_arb: shares one single-port, 1-cycle-latency SRAM between the
// RV core's instruction fetch port (i_*) and data load/store port (d_*).
// D has default priority; a wait counter forces an I grant after I has been
// denied MAX_WAIT consecutive cycles, so fetch always makes progress.
// Read responses are steered back to their owner through a one-entry tag.
//
// Optional build macro: SVC_RV_SRAM_ARB_STATS_EN adds grant/conflict counters
// (stat_i_grants, stat_d_grants, stat_conflicts). Arbitration is unaffected.
module svc_rv_sram_arb #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [AW-1:0]     i_req_addr,
  output logic              i_rd_valid,
  output logic [DW-1:0]     i_rd_data,

  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [AW-1:0]     d_req_addr,
  input  logic [DW-1:0]     d_req_wdata,
  input  logic [DW/8-1:0]   d_req_wstrb,
  output logic              d_rd_valid,
  output logic [DW-1:0]     d_rd_data,

  output logic              sram_en,
  output logic              sram_we,
  output logic [AW-1:0]     sram_addr,
  output logic [DW-1:0]     sram_wdata,
  output logic [DW/8-1:0]   sram_wstrb,
  input  logic [DW-1:0]     sram_rdata
`ifdef SVC_RV_SRAM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_i_grants,
  output logic [CNT_W-1:0]  stat_d_grants,
  output logic [CNT_W-1:0]  stat_conflicts
`endif
);

  localparam int SW = DW / 8;
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;
  logic       force_i;
  logic       i_grant;
  logic       d_grant;
  logic       pend;
  logic       owner_d;

  // Grant decision: D by default, I when alone or when it has starved long
  // enough. Nothing is granted while reset is held so the SRAM stays idle.
  always_comb begin
    force_i = (wait_cnt == MAX_WAIT_C);
    i_grant = !rst && i_req_valid && (!d_req_valid || force_i);
    d_grant = !rst && d_req_valid && !(i_req_valid && force_i);
  end

  assign i_req_ready = i_grant;
  assign d_req_ready = d_grant;

  // SRAM command mirrors the winning request; idle fields are held at zero.
  always_comb begin
    sram_en    = i_grant || d_grant;
    sram_we    = d_grant && d_req_we;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wstrb = '0;
    if (i_grant) begin
      sram_addr = i_req_addr;
    end else if (d_grant) begin
      sram_addr  = d_req_addr;
      sram_wdata = d_req_wdata;
      if (d_req_we) begin
        sram_wstrb = d_req_wstrb;
      end
    end
  end

  // Starvation counter: counts consecutive cycles I is valid but denied,
  // saturating at MAX_WAIT; any idle or accepted I cycle restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (!i_req_valid || i_grant) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt < MAX_WAIT_C) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Response tag: remembers that a read was issued and which port owns it.
  // Writes leave pend low so they never produce a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= 1'b0;
      owner_d <= 1'b0;
    end else begin
      pend    <= sram_en && !sram_we;
      owner_d <= d_grant;
    end
  end

  // Response steering: data passes straight through from the SRAM, gated to
  // zero on the port that does not own the current response.
  always_comb begin
    i_rd_valid = pend && !owner_d;
    d_rd_valid = pend && owner_d;
    i_rd_data  = i_rd_valid ? sram_rdata : '0;
    d_rd_data  = d_rd_valid ? sram_rdata : '0;
  end

`ifdef SVC_RV_SRAM_ARB_STATS_EN
  // Statistics: acceptances per port and cycles where both ports contended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_i_grants  <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (i_grant) begin
        stat_i_grants <= stat_i_grants + 1'b1;
      end
      if (d_grant) begin
        stat_d_grants <= stat_d_grants + 1'b1;
      end
      if (i_req_valid && d_req_valid) begin
        stat_conflicts <= stat_conflicts + 1'b1;
      end
    end
  end
`endif

  // Byte-lane count is only meaningful when DW is a whole number of bytes.
  logic [SW-1:0] unused_lane_chk;
  assign unused_lane_chk = d_req_wstrb & {SW{1'b0}};

endmodule

// File: tb/tb_svc_rv_sram_arb.sv
// Directed bench for svc_rv_sram_arb with a behavioural SRAM, a reference
// memory image and a response scoreboard.
module tb_svc_rv_sram_arb;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MW = 4;

  logic            clk;
  logic            rst;
  logic            i_req_valid;
  logic            i_req_ready;
  logic [AW-1:0]   i_req_addr;
  logic            i_rd_valid;
  logic [DW-1:0]   i_rd_data;
  logic            d_req_valid;
  logic            d_req_ready;
  logic            d_req_we;
  logic [AW-1:0]   d_req_addr;
  logic [DW-1:0]   d_req_wdata;
  logic [3:0]      d_req_wstrb;
  logic            d_rd_valid;
  logic [DW-1:0]   d_rd_data;
  logic            sram_en;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_wdata;
  logic [3:0]      sram_wstrb;
  logic [DW-1:0]   sram_rdata;
`ifdef SVC_RV_SRAM_ARB_STATS_EN
  logic [31:0]     stat_i_grants;
  logic [31:0]     stat_d_grants;
  logic [31:0]     stat_conflicts;
`endif

  svc_rv_sram_arb #(.AW(AW), .DW(DW), .MAX_WAIT(MW), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_req_addr  (i_req_addr),
    .i_rd_valid  (i_rd_valid),
    .i_rd_data   (i_rd_data),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_req_we    (d_req_we),
    .d_req_addr  (d_req_addr),
    .d_req_wdata (d_req_wdata),
    .d_req_wstrb (d_req_wstrb),
    .d_rd_valid  (d_rd_valid),
    .d_rd_data   (d_rd_data),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_wstrb  (sram_wstrb),
    .sram_rdata  (sram_rdata)
`ifdef SVC_RV_SRAM_ARB_STATS_EN
    ,
    .stat_i_grants  (stat_i_grants),
    .stat_d_grants  (stat_d_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  typedef struct packed {
    logic        iv;
    logic        dv;
    logic [31:0] data;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] sram_mem [0:1023];
  int          vectors = 0;
  int          miscompares = 0;
  int          wait_m = 0;
  logic [31:0] last_i_data;
  logic [31:0] last_d_data;
  logic        last_i_ready;
  logic        gi;
  logic        gd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM with byte enables and 1-cycle read latency.
  initial begin
    for (int n = 0; n < 1024; n++) sram_mem[n] = 32'(n * 4);
    sram_mem[9] = 32'h11223344;
    forever begin
      @(posedge clk);
      if (sram_en) begin
        if (sram_we) begin
          for (int b = 0; b < 4; b++)
            if (sram_wstrb[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end else begin
          sram_rdata <= sram_mem[sram_addr];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, return at posedge+1.
  task automatic step(input logic iv, input logic [AW-1:0] ia,
                      input logic dv, input logic dwe, input logic [AW-1:0] da,
                      input logic [31:0] dwd, input logic [3:0] dws,
                      output logic oi, output logic od);
    resp_t er;
    resp_t nr;
    logic  ei;
    logic  ed;
    i_req_valid = iv;
    i_req_addr  = ia;
    d_req_valid = dv;
    d_req_we    = dwe;
    d_req_addr  = da;
    d_req_wdata = dwd;
    d_req_wstrb = dws;
    @(negedge clk);
    if (sb.size() > 0) er = sb.pop_front();
    else er = '0;
    chk("i_rd_valid", 64'(i_rd_valid), 64'(er.iv));
    chk("d_rd_valid", 64'(d_rd_valid), 64'(er.dv));
    chk("i_rd_data", 64'(i_rd_data), er.iv ? 64'(er.data) : 64'd0);
    chk("d_rd_data", 64'(d_rd_data), er.dv ? 64'(er.data) : 64'd0);
    last_i_data  = i_rd_data;
    last_d_data  = d_rd_data;
    last_i_ready = i_req_ready;
    ei = iv && (!dv || wait_m == MW);
    ed = dv && !ei;
    chk("i_req_ready", 64'(i_req_ready), 64'(ei));
    chk("d_req_ready", 64'(d_req_ready), 64'(ed));
    chk("sram_en", 64'(sram_en), 64'(ei || ed));
    chk("sram_we", 64'(sram_we), 64'(ed && dwe));
    chk("sram_addr", 64'(sram_addr), ei ? 64'(ia) : (ed ? 64'(da) : 64'd0));
    chk("sram_wdata", 64'(sram_wdata), ed ? 64'(dwd) : 64'd0);
    chk("sram_wstrb", 64'(sram_wstrb), (ed && dwe) ? 64'(dws) : 64'd0);
    nr.iv   = ei;
    nr.dv   = ed && !dwe;
    nr.data = ei ? ref_mem[ia] : (ed ? ref_mem[da] : 32'd0);
    sb.push_back(nr);
    if (ed && dwe)
      for (int b = 0; b < 4; b++)
        if (dws[b]) ref_mem[da][8*b +: 8] = dwd[8*b +: 8];
    if (!iv || ei) wait_m = 0;
    else if (wait_m < MW) wait_m++;
    oi = ei;
    od = ed;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    logic a;
    logic b;
    step(1'b0, '0, 1'b0, 1'b0, '0, 32'd0, 4'd0, a, b);
  endtask

  initial begin
    logic [AW-1:0] ia_c;
    logic [AW-1:0] da_c;
    int            consec;
    int            maxc;
    int            igr;

    for (int n = 0; n < 1024; n++) ref_mem[n] = 32'(n * 4);
    ref_mem[9] = 32'h11223344;

    // Reset state, with both requesters pushing
    rst = 1'b1;
    i_req_valid = 1'b1; i_req_addr = '0;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = '0;
    d_req_wdata = '0; d_req_wstrb = '0;
    @(negedge clk);
    chk("rst_sram_en", 64'(sram_en), 64'd0);
    chk("rst_i_rd_valid", 64'(i_rd_valid), 64'd0);
    chk("rst_d_rd_valid", 64'(d_rd_valid), 64'd0);
    chk("rst_i_rd_data", 64'(i_rd_data), 64'd0);
    chk("rst_d_rd_data", 64'(d_rd_data), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;

    // I-only stream, addresses 0..7
    for (int k = 0; k < 8; k++) step(1'b1, AW'(k), 1'b0, 1'b0, '0, 32'd0, 4'd0, gi, gd);
    idle();

    // D full-word write then read-back
    step(1'b0, '0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF, gi, gd);
    step(1'b0, '0, 1'b1, 1'b0, 10'd5, 32'd0, 4'd0, gi, gd);
    idle();
    chk("d_readback", 64'(last_d_data), 64'h00000000DEADBEEF);

    // Byte-lane write then I read of the same word
    step(1'b0, '0, 1'b1, 1'b1, 10'd9, 32'h0000AB00, 4'b0010, gi, gd);
    step(1'b1, 10'd9, 1'b0, 1'b0, '0, 32'd0, 4'd0, gi, gd);
    idle();
    chk("byte_merge", 64'(last_i_data), 64'h000000001122AB44);

    // D write and I read in the same cycle: write first, I sees new data
    step(1'b1, 10'd20, 1'b1, 1'b1, 10'd20, 32'hCAFE0001, 4'hF, gi, gd);
    step(1'b1, 10'd20, 1'b0, 1'b0, '0, 32'd0, 4'd0, gi, gd);
    idle();
    chk("i_after_d_write", 64'(last_i_data), 64'h00000000CAFE0001);

    // Reset with a read in flight
    step(1'b1, 10'd3, 1'b0, 1'b0, '0, 32'd0, 4'd0, gi, gd);
    rst = 1'b1;
    #1;
    chk("rst_drop_i_rd_valid", 64'(i_rd_valid), 64'd0);
    sb.delete();
    wait_m = 0;
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    @(negedge clk);
    chk("rst_hold_sram_en", 64'(sram_en), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    idle();
`ifdef SVC_RV_SRAM_ARB_STATS_EN
    chk("stat_i_zero", 64'(stat_i_grants), 64'd0);
    chk("stat_d_zero", 64'(stat_d_grants), 64'd0);
    chk("stat_c_zero", 64'(stat_conflicts), 64'd0);
`endif

    // Continuous contention: D x4, I x1, repeating
    ia_c = '0; da_c = 10'd8; consec = 0; maxc = 0; igr = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, ia_c, 1'b1, 1'b0, da_c, 32'd0, 4'd0, gi, gd);
      if (last_i_ready) begin
        igr++;
        consec = 0;
      end else begin
        consec++;
        if (consec > maxc) maxc = consec;
      end
      if (gi) ia_c = ia_c + 1'b1;
      if (gd) da_c = da_c + 1'b1;
    end
    idle();
    chk("i_wins_in_10", 64'(igr), 64'd2);
    chk("max_i_deny", 64'(maxc), 64'd4);
`ifdef SVC_RV_SRAM_ARB_STATS_EN
    chk("stat_conflicts", 64'(stat_conflicts), 64'd10);
    chk("stat_d_grants", 64'(stat_d_grants), 64'd8);
    chk("stat_i_grants", 64'(stat_i_grants), 64'd2);
`endif
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
